la_readout: RTL and testbench
=============================

# la_readout

Downstream companion of the logic analyzer capture core. It arms the analyzer and waits for the capture to finish. It then reads the circular capture buffer out of the dual-port BRAM in chronological order, starting at the reported capture start and wrapping modulo the buffer size. Words leave on a valid/ready stream with a last marker, and the block then disarms the analyzer so the next capture can start.

## Interface
Parameters:
- CAPTURE_WIDTH, 32, width of one captured sample (BRAM data width).
- CAPTURE_DEPTH, 10, log2 of buffer size; samples per capture N = 2^CAPTURE_DEPTH.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; same clock as the analyzer BRAM read port.
- rst  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle request to arm the analyzer and read one capture.
- i_abort  in  1  one-cycle request to cancel; returns to IDLE from any state.
- o_la_enable  out  1  drives analyzer enable.
- i_finished  in  1  analyzer finished flag; already in clk domain.
- i_capture_start  in  32  index of the oldest sample; only bits [CAPTURE_DEPTH-1:0] are used.
- o_bram_addr  out  32  BRAM read address; upper bits are always 0.
- i_bram_data  in  CAPTURE_WIDTH  BRAM read data; valid exactly 1 cycle after the address.
- o_data  out  CAPTURE_WIDTH  stream data.
- o_valid  out  1  stream valid.
- i_ready  in  1  stream ready; a transfer occurs when o_valid & i_ready.
- o_last  out  1  high with the final (N-th) word.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse when a full readout completes.
- o_count  out  32  words transferred in the current readout.

## Operation
- States: IDLE, WAIT_FIN, READ, DONE.
- IDLE:
  - On i_start, go to WAIT_FIN and set o_la_enable=1.
  - i_start in any other state is ignored.
- WAIT_FIN:
  - When i_finished=1, latch p = i_capture_start[CAPTURE_DEPTH-1:0].
  - Clear the issue counter, in-flight flag and o_count, then go to READ.
- READ: issue up to N reads.
  - Read address is (p + issued) mod N, i.e. CAPTURE_DEPTH-bit wrap-around.
  - Data returns into a 2-entry output FIFO.
  - A read may issue in a cycle only if (FIFO occupancy after this cycle's pop) + (in-flight read) < 2. This is required so no returned word is ever dropped under backpressure.
  - issued counts 0..N and needs CAPTURE_DEPTH+1 bits.
  - When issued == N, the FIFO is empty and nothing is in flight, go to DONE.
- Stream:
  - o_valid = FIFO non-empty; o_data = FIFO head.
  - o_last = head is word number N-1 (0-based).
  - o_count increments on each transfer.
- DONE:
  - o_la_enable=0 and o_done pulses in the entry cycle.
  - Wait for i_finished=0, then go to IDLE.
  - o_count holds its value until the next i_start.
- i_abort, in any state:
  - Next state is IDLE, o_la_enable=0, FIFO flushed, any in-flight read discarded.
  - o_done is not pulsed.
  - i_abort has priority over i_start and all other transitions in the same cycle.
- o_data and o_bram_addr are don't-care while o_valid=0 / no read is issued. o_bram_addr holds its last value.

## Timing
- Reset (rst=0 at a clk edge): state IDLE, o_la_enable=0, o_valid=0, o_last=0, o_busy=0, o_done=0, o_count=0, o_bram_addr=0, o_data=0, FIFO empty.
- Reset mid-readout has the same effect; a partial stream is abandoned.
- Latencies:
  - i_start at cycle t gives o_la_enable=1 and o_busy=1 at t+1.
  - i_finished seen at t gives the first address at t+1 and first o_valid at t+3 (address reg, BRAM, FIFO write).
- Sustained throughput is 1 word/cycle while i_ready=1.
- With i_ready=0, at most 2 words are buffered and o_data/o_last stay stable until accepted.
- Total cycles from entering READ to DONE with i_ready tied high: N+3.

## Test plan
- Basic:
  - Stimulus: CAPTURE_DEPTH=4, BRAM[k]=k, i_capture_start=0, i_ready=1.
  - Response: 16 words 0..15; o_last only on word 15; o_done pulses once; o_count=16; o_la_enable drops on DONE entry.
- Wrap:
  - Stimulus: i_capture_start=13.
  - Response: sequence 13,14,15,0,...,12; o_bram_addr never exceeds 15.
- Backpressure:
  - Stimulus: random i_ready at 30% duty, including a 20-cycle stall.
  - Response: no word lost, duplicated or reordered; o_data stable while o_valid & !i_ready.
- Abort:
  - Stimulus: i_abort after 5 transfers.
  - Response: next cycle IDLE, o_valid=0, o_la_enable=0, no o_done.
  - Follow-up: a new i_start yields a full correct readout.
- Reset:
  - Stimulus: rst=0 for one cycle mid-READ.
  - Response: all outputs at reset values on the next cycle; i_start ignored during rst=0.
- Rearm handshake:
  - Stimulus: hold i_finished=1 for 10 cycles after DONE.
  - Response: block stays in DONE with o_busy=1, then returns to IDLE one cycle after i_finished falls; i_start during DONE is ignored.

Source files
------------

// File: rtl/la_readout.sv
// Logic-analyzer readout: arms the capture core, waits for it to finish, then streams the
// circular capture buffer out of BRAM oldest-first through a 2-entry skid FIFO.
module la_readout #(
  parameter int unsigned CAPTURE_WIDTH = 32,
  parameter int unsigned CAPTURE_DEPTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_abort,
  output logic                     o_la_enable,
  input  logic                     i_finished,
  input  logic [31:0]              i_capture_start,
  output logic [31:0]              o_bram_addr,
  input  logic [CAPTURE_WIDTH-1:0] i_bram_data,
  output logic [CAPTURE_WIDTH-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [31:0]              o_count
);

  localparam logic [CAPTURE_DEPTH:0]   NumWords  = {1'b1, {CAPTURE_DEPTH{1'b0}}};
  localparam logic [CAPTURE_DEPTH:0]   LastIssue = {1'b0, {CAPTURE_DEPTH{1'b1}}};
  localparam logic [CAPTURE_DEPTH:0]   IssueOne  = {{CAPTURE_DEPTH{1'b0}}, 1'b1};
  localparam logic [CAPTURE_DEPTH-1:0] AddrOne   = IssueOne[CAPTURE_DEPTH-1:0];
  localparam logic [31:0]              LastIdx   = 32'(LastIssue);

  typedef enum logic [1:0] {StIdle, StWaitFin, StRead, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CAPTURE_DEPTH-1:0] addr_q, addr_d;       // address of the next read to issue
  logic [CAPTURE_DEPTH:0]   issued_q, issued_d;
  logic                     inflight_q, inflight_d; // BRAM data for last cycle's read is on the bus
  logic [CAPTURE_WIDTH-1:0] fifo_q [2];
  logic [CAPTURE_WIDTH-1:0] fifo_d [2];
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0]               occ_q, occ_d;
  logic [31:0]              count_q, count_d;
  logic                     done_q, done_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occ_after_pop;
  logic [1:0] committed;

  // Only the low CAPTURE_DEPTH bits of the start index address the buffer.
  logic unused_start_bits;
  assign unused_start_bits = ^i_capture_start[31:CAPTURE_DEPTH];

  // Next-state logic: FSM, read issue with FIFO credit check, FIFO and counters.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    inflight_d = 1'b0;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    count_d    = count_q;
    done_d     = 1'b0;

    pop           = (occ_q != 2'd0) && i_ready;
    push          = inflight_q;
    occ_after_pop = occ_q - {1'b0, pop};
    committed     = occ_after_pop + {1'b0, inflight_q};
    // Only issue when the returning word is guaranteed a FIFO slot.
    issue         = (state_q == StRead) && (issued_q != NumWords) && (committed < 2'd2);

    if (push) begin
      fifo_d[wr_ptr_q] = i_bram_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      count_d  = count_q + 32'd1;
    end
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};

    if (issue) begin
      inflight_d = 1'b1;
      issued_d   = issued_q + IssueOne;
      // Keep the final address on the bus rather than wrapping back to the start.
      if (issued_q != LastIssue) begin
        addr_d = addr_q + AddrOne;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StWaitFin;
          count_d = '0;
        end
      end
      StWaitFin: begin
        if (i_finished) begin
          state_d    = StRead;
          addr_d     = i_capture_start[CAPTURE_DEPTH-1:0];
          issued_d   = '0;
          inflight_d = 1'b0;
          count_d    = '0;
        end
      end
      StRead: begin
        if ((issued_q == NumWords) && (occ_q == 2'd0) && !inflight_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        if (!i_finished) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything: drop buffered and in-flight data, no done pulse.
    if (i_abort) begin
      state_d    = StIdle;
      done_d     = 1'b0;
      inflight_d = 1'b0;
      occ_d      = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
      done_q     <= done_d;
    end
  end

  // Outputs decoded from registered state; the head's index equals the transfer count.
  always_comb begin
    o_la_enable = (state_q == StWaitFin) || (state_q == StRead);
    o_busy      = (state_q != StIdle);
    o_done      = done_q;
    o_valid     = (occ_q != 2'd0);
    o_data      = fifo_q[rd_ptr_q];
    o_last      = o_valid && (count_q == LastIdx);
    o_count     = count_q;
    o_bram_addr = 32'(addr_q);
  end

endmodule

// File: tb/tb_la_readout.sv
// Self-checking bench for la_readout with a synchronous BRAM model and a
// modular-arithmetic reference for the expected chronological word order.
module tb_la_readout;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;
  localparam int unsigned N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start, i_abort, i_finished, i_ready;
  logic [31:0]  i_capture_start;
  logic [W-1:0] bram_data;
  logic         o_la_enable, o_valid, o_last, o_busy, o_done;
  logic [31:0]  o_bram_addr, o_count;
  logic [W-1:0] o_data;

  la_readout #(
    .CAPTURE_WIDTH(W),
    .CAPTURE_DEPTH(D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .o_la_enable    (o_la_enable),
    .i_finished     (i_finished),
    .i_capture_start(i_capture_start),
    .o_bram_addr    (o_bram_addr),
    .i_bram_data    (bram_data),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_last         (o_last),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_count        (o_count)
  );

  always #5 clk = ~clk;

  // Capture buffer: synchronous read, data one cycle after the address.
  logic [W-1:0] mem [N];
  always @(posedge clk) bram_data <= mem[o_bram_addr[D-1:0]];

  int checks   = 0;
  int failures = 0;

  // Results of the most recent run_readout.
  logic [W-1:0] got_q[$];
  logic         last_q[$];
  int           done_cnt, first_valid_j, done_j;
  bit           timed_out, addr_bad, unstable, rearm_bad, idle_after;
  logic         la_at_start, busy_at_start, la_at_done;
  logic [31:0]  count_at_done, count_after;

  // Drives one complete capture readout and records what came out of the stream.
  task automatic run_readout(input int cs, input bit ident, input int ready_pct,
                             input int stall_at, input int hold);
    bit           prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;
    got_q.delete();
    last_q.delete();
    done_cnt = 0; first_valid_j = -1; done_j = -1;
    timed_out = 0; addr_bad = 0; unstable = 0; rearm_bad = 0; idle_after = 0;
    for (int k = 0; k < int'(N); k++) mem[k] = ident ? W'(k) : W'($urandom());
    i_capture_start = ($urandom() & ~32'(N - 1)) | 32'(cs);
    i_start = 1'b1; i_finished = 1'b0; i_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    la_at_start = o_la_enable;
    busy_at_start = o_busy;
    @(negedge clk);
    @(negedge clk);
    i_finished = 1'b1;
    prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    for (int j = 1; j <= 400 && done_j < 0; j++) begin
      @(negedge clk);
      if (prev_stall && (!o_valid || o_data !== prev_data || o_last !== prev_last)) unstable = 1;
      if (o_bram_addr > 32'(N - 1)) addr_bad = 1;
      if (o_valid && first_valid_j < 0) first_valid_j = j;
      if (o_done) begin
        done_cnt++; done_j = j; la_at_done = o_la_enable; count_at_done = o_count;
      end
      if (stall_at >= 0 && j >= stall_at && j < stall_at + 20) i_ready = 1'b0;
      else i_ready = ($urandom_range(0, 99) < ready_pct);
      if (o_valid && i_ready) begin
        got_q.push_back(o_data);
        last_q.push_back(o_last);
      end
      prev_stall = o_valid && !i_ready;
      prev_data = o_data;
      prev_last = o_last;
    end
    if (done_j < 0) begin
      timed_out = 1;
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      i_start = (i == 2);
      @(negedge clk);
      if (o_busy !== 1'b1) rearm_bad = 1;
      if (o_done) done_cnt++;
    end
    i_start = 1'b0;
    i_finished = 1'b0;
    @(negedge clk);
    idle_after = (o_busy === 1'b0);
    count_after = o_count;
    if (o_done) done_cnt++;
    @(negedge clk);
    if (o_busy !== 1'b0) idle_after = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_start = 1'b1; i_abort = 1'b0; i_finished = 1'b0; i_ready = 1'b1;
    i_capture_start = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({o_la_enable, o_valid, o_last, o_busy, o_done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000",
               {o_la_enable, o_valid, o_last, o_busy, o_done});
    end
    checks++;
    if (o_count !== 32'd0 || o_bram_addr !== 32'd0 || o_data !== '0) begin
      failures++;
      $display("FAIL reset_values count=%0d addr=%0d data=%h exp=0", o_count, o_bram_addr, o_data);
    end
    rst = 1'b1; i_start = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      failures++; $display("FAIL reset_start_ignored busy=%b exp=0", o_busy);
    end
  endtask

  task automatic test_basic();
    run_readout(0, 1'b1, 100, -1, 0);
    checks++;
    if (timed_out || got_q.size() != N) begin
      failures++; $display("FAIL basic_len words=%0d exp=%0d timeout=%0d", got_q.size(), N, timed_out);
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        checks++;
        if (got_q[k] !== W'(k) || last_q[k] !== (k == int'(N) - 1)) begin
          failures++;
          $display("FAIL basic_word%0d got=%0d last=%b exp=%0d last=%b", k, got_q[k], last_q[k], k,
                   (k == int'(N) - 1));
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    checks++;
    if (la_at_start !== 1'b1 || busy_at_start !== 1'b1) begin
      failures++; $display("FAIL basic_arm la=%b busy=%b exp=1 1", la_at_start, busy_at_start);
    end
    checks++;
    if (la_at_done !== 1'b0) begin failures++; $display("FAIL basic_la_at_done got=%b exp=0", la_at_done); end
    checks++;
    if (count_at_done !== 32'(N) || count_after !== 32'(N)) begin
      failures++; $display("FAIL basic_count got=%0d/%0d exp=%0d", count_at_done, count_after, N);
    end
    checks++;
    if (first_valid_j != 3) begin failures++; $display("FAIL basic_first_valid got=%0d exp=3", first_valid_j); end
    checks++;
    if (done_j != int'(N) + 4) begin
      failures++; $display("FAIL basic_done_latency got=%0d exp=%0d", done_j, N + 4);
    end
    checks++;
    if (!idle_after) begin failures++; $display("FAIL basic_idle_after got=0 exp=1"); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 2; r++) begin
      int cs;
      cs = (r == 0) ? 13 : int'($urandom_range(1, N - 1));
      run_readout(cs, r == 0, 100, -1, 0);
      checks++;
      if (timed_out || got_q.size() != N) begin
        failures++; $display("FAIL wrap_len words=%0d exp=%0d", got_q.size(), N);
      end else begin
        for (int k = 0; k < int'(N); k++) begin
          checks++;
          if (got_q[k] !== mem[(cs + k) % int'(N)] || last_q[k] !== (k == int'(N) - 1)) begin
            failures++;
            $display("FAIL wrap_cs%0d_word%0d got=%h exp=%h", cs, k, got_q[k], mem[(cs + k) % int'(N)]);
          end
        end
      end
      checks++;
      if (addr_bad) begin failures++; $display("FAIL wrap_addr_range got=over exp<=%0d", N - 1); end
    end
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 3; r++) begin
      int cs;
      cs = int'($urandom_range(0, N - 1));
      run_readout(cs, 1'b0, 30, (r == 0) ? 4 : -1, 0);
      checks++;
      if (timed_out || got_q.size() != N) begin
        failures++; $display("FAIL bp_len words=%0d exp=%0d timeout=%0d", got_q.size(), N, timed_out);
      end else begin
        for (int k = 0; k < int'(N); k++) begin
          checks++;
          if (got_q[k] !== mem[(cs + k) % int'(N)] || last_q[k] !== (k == int'(N) - 1)) begin
            failures++;
            $display("FAIL bp_word%0d got=%h last=%b exp=%h", k, got_q[k], last_q[k],
                     mem[(cs + k) % int'(N)]);
          end
        end
      end
      checks++;
      if (unstable) begin failures++; $display("FAIL bp_stable got=changed exp=held"); end
      checks++;
      if (done_cnt != 1) begin failures++; $display("FAIL bp_done_pulses got=%0d exp=1", done_cnt); end
    end
  endtask

  task automatic test_abort();
    int n, dones, cs;
    n = 0; dones = 0;
    for (int k = 0; k < int'(N); k++) mem[k] = $urandom();
    i_capture_start = 32'(3);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    i_finished = 1'b1; i_ready = 1'b1;
    for (int j = 0; j < 100 && n < 5; j++) begin
      @(negedge clk);
      if (o_valid && i_ready) n++;
    end
    @(negedge clk);
    // Abort and start together: abort must win.
    i_abort = 1'b1; i_start = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    i_abort = 1'b0; i_start = 1'b0;
    checks++;
    if (n != 5) begin failures++; $display("FAIL abort_reach5 got=%0d exp=5", n); end
    checks++;
    if ({o_busy, o_valid, o_la_enable, o_done} !== 4'b0) begin
      failures++;
      $display("FAIL abort_state got=%b exp=0000", {o_busy, o_valid, o_la_enable, o_done});
    end
    i_finished = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (o_done || o_busy) dones++;
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", dones); end
    cs = int'($urandom_range(0, N - 1));
    run_readout(cs, 1'b0, 70, -1, 0);
    checks++;
    if (timed_out || got_q.size() != N) begin
      failures++; $display("FAIL abort_followup_len words=%0d exp=%0d", got_q.size(), N);
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        checks++;
        if (got_q[k] !== mem[(cs + k) % int'(N)]) begin
          failures++;
          $display("FAIL abort_followup_word%0d got=%h exp=%h", k, got_q[k], mem[(cs + k) % int'(N)]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, cs;
    n = 0;
    for (int k = 0; k < int'(N); k++) mem[k] = $urandom();
    i_capture_start = 32'(9);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    i_finished = 1'b1; i_ready = 1'b1;
    for (int j = 0; j < 100 && n < 3; j++) begin
      @(negedge clk);
      if (o_valid && i_ready) n++;
    end
    rst = 1'b0; i_start = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_la_enable, o_valid, o_last, o_busy, o_done} !== 5'b0) begin
      failures++;
      $display("FAIL midreset_flags got=%b exp=00000",
               {o_la_enable, o_valid, o_last, o_busy, o_done});
    end
    checks++;
    if (o_count !== 32'd0 || o_bram_addr !== 32'd0 || o_data !== '0) begin
      failures++;
      $display("FAIL midreset_values count=%0d addr=%0d data=%h exp=0", o_count, o_bram_addr, o_data);
    end
    rst = 1'b1; i_start = 1'b0; i_finished = 1'b0;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL midreset_start_ignored busy=%b exp=0", o_busy); end
    cs = int'($urandom_range(0, N - 1));
    run_readout(cs, 1'b0, 100, -1, 0);
    checks++;
    if (timed_out || got_q.size() != N) begin
      failures++; $display("FAIL midreset_followup_len words=%0d exp=%0d", got_q.size(), N);
    end else begin
      for (int k = 0; k < int'(N); k++) begin
        checks++;
        if (got_q[k] !== mem[(cs + k) % int'(N)]) begin
          failures++;
          $display("FAIL midreset_word%0d got=%h exp=%h", k, got_q[k], mem[(cs + k) % int'(N)]);
        end
      end
    end
  endtask

  task automatic test_rearm();
    int cs;
    cs = int'($urandom_range(0, N - 1));
    run_readout(cs, 1'b0, 100, -1, 10);
    checks++;
    if (timed_out || rearm_bad) begin
      failures++; $display("FAIL rearm_hold busy_dropped=%0d timeout=%0d exp=0 0", rearm_bad, timed_out);
    end
    checks++;
    if (!idle_after) begin failures++; $display("FAIL rearm_idle_after got=0 exp=1"); end
    checks++;
    if (done_cnt != 1) begin failures++; $display("FAIL rearm_done_pulses got=%0d exp=1", done_cnt); end
    checks++;
    if (count_after !== 32'(N)) begin
      failures++; $display("FAIL rearm_count_hold got=%0d exp=%0d", count_after, N);
    end
    checks++;
    if (got_q.size() != N || got_q[N-1] !== mem[(cs + int'(N) - 1) % int'(N)]) begin
      failures++; $display("FAIL rearm_words words=%0d exp=%0d", got_q.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_rearm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
